// File: rtl/alu_mul_sequencer_pkg.sv
// Shared EX-stage definitions: ALU op encodings and the multiply sequencer state encoding.
package alu_mul_sequencer_pkg;

  localparam logic [2:0] OP_NOR = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle between the EX stage and the multiply sequencer: request, ALU borrow path, result.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             ready;
  logic             stall;
  logic             alu_own;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_out;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;

  modport slave (
    input  start, op_a, op_b, flush, alu_out,
    output ready, stall, alu_own, alu_a, alu_b, alu_op, done, result_hi, result_lo
  );

  modport master (
    output start, op_a, op_b, flush, alu_out,
    input  ready, stall, alu_own, alu_a, alu_b, alu_op, done, result_hi, result_lo
  );
endinterface

// File: rtl/alu_mul_sequencer_mul_zero_shift.sv
// Early-termination helper, only present when MUL_EARLY_TERM_EN is defined: detects that the
// remaining multiplier bits are zero and right-shifts {acc,mpl} by the remaining count.
`ifdef MUL_EARLY_TERM_EN
module mul_zero_shift #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mpl,
  output logic             o_zero,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mpl
);
  logic [CNT_W-1:0] w_rem;
  logic [WIDTH-1:0] w_mask;

  assign w_rem  = CNT_W'(WIDTH) - i_cnt;
  // a shift by WIDTH clears every bit, so rem==WIDTH yields an all-ones mask
  assign w_mask = ~({WIDTH{1'b1}} << w_rem);
  assign o_zero = ~|(i_mpl & w_mask);
  assign {o_acc, o_mpl} = {i_acc, i_mpl} >> w_rem;
endmodule
`endif

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTHxWIDTH shift-add multiplier that borrows the EX-stage ALU (ADD) once per bit.
// Optional MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_mul_sequencer_if.slave  bus
);
  mul_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_mcand, r_acc, r_mpl;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_res_hi, r_res_lo;

  logic             w_carry, w_last, w_fin, w_accept, w_commit;
  logic [WIDTH-1:0] w_it_acc, w_it_mpl, w_acc_nxt, w_mpl_nxt;

  assign w_carry  = bus.alu_out < r_acc;
  assign w_it_acc = {w_carry, bus.alu_out[WIDTH-1:1]};
  assign w_it_mpl = {bus.alu_out[0], r_mpl[WIDTH-1:1]};
  assign w_last   = r_cnt == CNT_W'(WIDTH - 1);
  assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;
  // a flush landing on the DONE cycle suppresses the result entirely
  assign w_commit = (r_state == DONE) && !bus.flush;

`ifdef MUL_EARLY_TERM_EN
  logic             w_zero;
  logic [WIDTH-1:0] w_sh_acc, w_sh_mpl;

  mul_zero_shift #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_zero_shift (
    .i_cnt  (r_cnt),
    .i_acc  (r_acc),
    .i_mpl  (r_mpl),
    .o_zero (w_zero),
    .o_acc  (w_sh_acc),
    .o_mpl  (w_sh_mpl)
  );

  assign w_acc_nxt = w_zero ? w_sh_acc : w_it_acc;
  assign w_mpl_nxt = w_zero ? w_sh_mpl : w_it_mpl;
  assign w_fin     = w_zero || w_last;
`else
  assign w_acc_nxt = w_it_acc;
  assign w_mpl_nxt = w_it_mpl;
  assign w_fin     = w_last;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (bus.flush) w_state_nxt = IDLE;
               else if (w_fin) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mpl    <= '0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= bus.op_a;
        r_acc   <= '0;
        r_mpl   <= bus.op_b;
        r_cnt   <= '0;
      end else if (r_state == RUN && !bus.flush) begin
        r_acc   <= w_acc_nxt;
        r_mpl   <= w_mpl_nxt;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_commit) begin
        r_res_hi <= r_acc;
        r_res_lo <= r_mpl;
      end
    end
  end

  always_comb begin
    bus.ready     = r_state == IDLE;
    bus.stall     = (r_state == RUN) || (r_state == DONE);
    bus.alu_own   = r_state == RUN;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_op    = OP_NOR;
    if (r_state == RUN) begin
      bus.alu_a   = r_acc;
      bus.alu_b   = r_mpl[0] ? r_mcand : '0;
      bus.alu_op  = OP_ADD;
    end
    bus.done      = w_commit;
    // the product is visible in the DONE cycle and held from the registers afterwards
    bus.result_hi = w_commit ? r_acc : r_res_hi;
    bus.result_lo = w_commit ? r_mpl : r_res_lo;
  end

endmodule
